// File: rtl/reset_src_filter.sv
// Conditions push-button, software and clock-manager lock reset sources into EXT_RESET / DCM_LOCKED.
// Optional watchdog trigger is built only when the macro RESET_WDT_EN is defined.
module reset_src_filter #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic [31:0] BTN_DEB_CNT     = 32'd100000,
    parameter logic [31:0] LOCK_STABLE_CNT = 32'd1024,
    parameter logic [31:0] EXT_PULSE_CNT   = 32'd256,
    parameter logic [31:0] WDT_TIMEOUT     = 32'h0100_0000
) (
    input  logic       MAIN_CLK,
    input  logic       MAIN_RESET_N,
    input  logic       RESET_BTN_N,
    input  logic       DCM_LOCKED_RAW,
    input  logic       SOFT_RESET_REQ,
    input  logic       CAUSE_CLR,
    input  logic       WDT_KICK,
    output logic       EXT_RESET,
    output logic       DCM_LOCKED,
    output logic [3:0] RESET_CAUSE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] btn_sync_r;
    logic [SYNC_STAGES-1:0] lock_sync_r;
    logic                   btn_s;
    logic                   lock_s;

    logic [31:0] deb_cnt_r;
    logic        deb_btn_r;
    logic        deb_btn_prev_r;
    logic        deb_fall_s;

    logic [31:0] lock_cnt_r;
    logic        dcm_locked_r;
    logic        lock_loss_s;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] pulse_cnt_r;
    logic        ext_reset_r;
    logic [3:0]  cause_r;
    logic [3:0]  cause_trig_s;
    logic        enter_assert_s;
    logic        pulse_inc_s;
    logic        wdt_trig_s;
    logic        trigger_s;

    assign btn_s  = btn_sync_r[SYNC_STAGES-1];
    assign lock_s = lock_sync_r[SYNC_STAGES-1];

    // Synchronise the asynchronous button and lock inputs.
    always_ff @(posedge MAIN_CLK or negedge MAIN_RESET_N) begin
        if (!MAIN_RESET_N) begin
            btn_sync_r  <= {SYNC_STAGES{1'b1}};
            lock_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            btn_sync_r  <= {btn_sync_r[SYNC_STAGES-2:0], RESET_BTN_N};
            lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], DCM_LOCKED_RAW};
        end
    end

    // Debounce: a new button level is accepted only after BTN_DEB_CNT consecutive differing samples.
    always_ff @(posedge MAIN_CLK or negedge MAIN_RESET_N) begin
        if (!MAIN_RESET_N) begin
            deb_cnt_r      <= 32'd0;
            deb_btn_r      <= 1'b1;
            deb_btn_prev_r <= 1'b1;
        end else begin
            deb_btn_prev_r <= deb_btn_r;
            if (btn_s != deb_btn_r) begin
                if (deb_cnt_r == (BTN_DEB_CNT - 32'd1)) begin
                    deb_btn_r <= btn_s;
                    deb_cnt_r <= 32'd0;
                end else begin
                    deb_cnt_r <= deb_cnt_r + 32'd1;
                end
            end else begin
                deb_cnt_r <= 32'd0;
            end
        end
    end

    assign deb_fall_s = deb_btn_prev_r & ~deb_btn_r;

    // Lock qualifier: rise is filtered by a saturating stability count, loss is immediate.
    always_ff @(posedge MAIN_CLK or negedge MAIN_RESET_N) begin
        if (!MAIN_RESET_N) begin
            lock_cnt_r   <= 32'd0;
            dcm_locked_r <= 1'b0;
        end else if (!lock_s) begin
            lock_cnt_r   <= 32'd0;
            dcm_locked_r <= 1'b0;
        end else begin
            if (lock_cnt_r != LOCK_STABLE_CNT) begin
                lock_cnt_r <= lock_cnt_r + 32'd1;
            end else begin
                lock_cnt_r <= lock_cnt_r;
            end
            if (lock_cnt_r == (LOCK_STABLE_CNT - 32'd1)) begin
                dcm_locked_r <= 1'b1;
            end else begin
                dcm_locked_r <= dcm_locked_r;
            end
        end
    end

    assign lock_loss_s = dcm_locked_r & ~lock_s;

`ifdef RESET_WDT_EN
    logic [31:0] wdt_cnt_r;

    // Watchdog counts idle locked cycles; any kick, lock loss or new pulse restarts it.
    always_ff @(posedge MAIN_CLK or negedge MAIN_RESET_N) begin
        if (!MAIN_RESET_N) begin
            wdt_cnt_r <= 32'd0;
        end else if (WDT_KICK || !dcm_locked_r || enter_assert_s) begin
            wdt_cnt_r <= 32'd0;
        end else if (state_r == IDLE) begin
            wdt_cnt_r <= wdt_cnt_r + 32'd1;
        end else begin
            wdt_cnt_r <= wdt_cnt_r;
        end
    end

    assign wdt_trig_s = dcm_locked_r && (state_r == IDLE) && !WDT_KICK &&
                        (wdt_cnt_r == (WDT_TIMEOUT - 32'd1));
`else
    logic [32:0] unused_s;

    assign unused_s   = {WDT_KICK, WDT_TIMEOUT};
    assign wdt_trig_s = 1'b0;
`endif

    assign trigger_s = deb_fall_s | SOFT_RESET_REQ | wdt_trig_s;

    // FSM state register.
    always_ff @(posedge MAIN_CLK or negedge MAIN_RESET_N) begin
        if (!MAIN_RESET_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (trigger_s) begin
                    next_state_s = ASSERT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ASSERT: begin
                if (pulse_cnt_r == (EXT_PULSE_CNT - 32'd1)) begin
                    if (deb_btn_r) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = HOLD;
                    end
                end else begin
                    next_state_s = ASSERT;
                end
            end
            HOLD: begin
                if (deb_btn_r) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM output logic: triggers only count (and record causes) while idle.
    always_comb begin
        enter_assert_s = 1'b0;
        pulse_inc_s    = 1'b0;
        cause_trig_s   = 4'h0;
        case (state_r)
            IDLE: begin
                enter_assert_s = trigger_s;
                cause_trig_s   = {wdt_trig_s, 1'b0, SOFT_RESET_REQ, deb_fall_s};
            end
            ASSERT: begin
                pulse_inc_s = 1'b1;
            end
            HOLD: begin
                pulse_inc_s = 1'b0;
            end
            default: begin
                pulse_inc_s = 1'b0;
            end
        endcase
    end

    // Pulse counter, registered EXT_RESET and sticky cause bits (a set beats a clear).
    always_ff @(posedge MAIN_CLK or negedge MAIN_RESET_N) begin
        if (!MAIN_RESET_N) begin
            pulse_cnt_r <= 32'd0;
            ext_reset_r <= 1'b0;
            cause_r     <= 4'h0;
        end else begin
            if (enter_assert_s) begin
                pulse_cnt_r <= 32'd0;
            end else if (pulse_inc_s) begin
                pulse_cnt_r <= pulse_cnt_r + 32'd1;
            end else begin
                pulse_cnt_r <= pulse_cnt_r;
            end
            ext_reset_r <= (next_state_s != IDLE);
            cause_r     <= (CAUSE_CLR ? 4'h0 : cause_r) | cause_trig_s |
                           {1'b0, lock_loss_s, 2'b00};
        end
    end

    assign EXT_RESET   = ext_reset_r;
    assign DCM_LOCKED  = dcm_locked_r;
    assign RESET_CAUSE = cause_r;

endmodule

// File: tb/tb_reset_src_filter.sv
// Self-checking bench for reset_src_filter: cycle model comparison plus directed literal checks.
// Watchdog scenarios run only when RESET_WDT_EN is defined.
module tb_reset_src_filter;

    localparam int S = 2;
    localparam int D = 8;
    localparam int L = 16;
    localparam int P = 32;
    localparam int T = 100;

    logic       MAIN_CLK;
    logic       MAIN_RESET_N;
    logic       RESET_BTN_N;
    logic       DCM_LOCKED_RAW;
    logic       SOFT_RESET_REQ;
    logic       CAUSE_CLR;
    logic       WDT_KICK;
    logic       EXT_RESET;
    logic       DCM_LOCKED;
    logic [3:0] RESET_CAUSE;

    int tests_run    = 0;
    int tests_failed = 0;
    int ext_high_cnt = 0;

    reset_src_filter #(
        .SYNC_STAGES    (S),
        .BTN_DEB_CNT    (32'd8),
        .LOCK_STABLE_CNT(32'd16),
        .EXT_PULSE_CNT  (32'd32),
        .WDT_TIMEOUT    (32'd100)
    ) dut (
        .MAIN_CLK      (MAIN_CLK),
        .MAIN_RESET_N  (MAIN_RESET_N),
        .RESET_BTN_N   (RESET_BTN_N),
        .DCM_LOCKED_RAW(DCM_LOCKED_RAW),
        .SOFT_RESET_REQ(SOFT_RESET_REQ),
        .CAUSE_CLR     (CAUSE_CLR),
        .WDT_KICK      (WDT_KICK),
        .EXT_RESET     (EXT_RESET),
        .DCM_LOCKED    (DCM_LOCKED),
        .RESET_CAUSE   (RESET_CAUSE)
    );

    initial MAIN_CLK = 1'b0;
    always #5 MAIN_CLK = ~MAIN_CLK;

    // ---------------- behavioural model ----------------
    // Model state: input histories, run lengths, remaining pulse cycles, hold flag, causes.
    bit       m_btn_hist  [S];
    bit       m_lock_hist [S];
    int       m_deb_run;
    bit       m_deb;
    bit       m_deb_prev;
    int       m_lock_run;
    int       m_left;
    bit       m_hold;
    bit [3:0] m_cause;
    int       m_wdt_age;

    bit       m_btn_s, m_lock_s, m_locked, m_idle, m_fall, m_wdt_fire, m_trig, m_ext;
    bit [3:0] m_set;

    always_comb begin
        m_btn_s    = m_btn_hist[S-1];
        m_lock_s   = m_lock_hist[S-1];
        m_locked   = (m_lock_run >= L);
        m_idle     = (m_left == 0) && !m_hold;
        m_fall     = m_deb_prev && !m_deb;
        m_wdt_fire = 1'b0;
`ifdef RESET_WDT_EN
        m_wdt_fire = m_locked && m_idle && (m_wdt_age == T - 1) && !WDT_KICK;
`endif
        m_trig     = m_fall || SOFT_RESET_REQ || m_wdt_fire;
        m_set      = {m_idle && m_wdt_fire, m_locked && !m_lock_s,
                      m_idle && SOFT_RESET_REQ, m_idle && m_fall};
        m_ext      = (m_left != 0) || m_hold;
    end

    always @(posedge MAIN_CLK or negedge MAIN_RESET_N) begin
        if (!MAIN_RESET_N) begin
            for (int i = 0; i < S; i++) begin
                m_btn_hist[i]  <= 1'b1;
                m_lock_hist[i] <= 1'b0;
            end
            m_deb_run  <= 0;
            m_deb      <= 1'b1;
            m_deb_prev <= 1'b1;
            m_lock_run <= 0;
            m_left     <= 0;
            m_hold     <= 1'b0;
            m_cause    <= 4'h0;
            m_wdt_age  <= 0;
        end else begin
            m_btn_hist[0]  <= RESET_BTN_N;
            m_lock_hist[0] <= DCM_LOCKED_RAW;
            for (int i = 1; i < S; i++) begin
                m_btn_hist[i]  <= m_btn_hist[i-1];
                m_lock_hist[i] <= m_lock_hist[i-1];
            end
            // Button level accepted after D consecutive differing samples.
            m_deb_prev <= m_deb;
            if (m_btn_s != m_deb) begin
                if (m_deb_run + 1 == D) begin
                    m_deb     <= m_btn_s;
                    m_deb_run <= 0;
                end else begin
                    m_deb_run <= m_deb_run + 1;
                end
            end else begin
                m_deb_run <= 0;
            end
            m_lock_run <= m_lock_s ? ((m_lock_run < L) ? m_lock_run + 1 : L) : 0;
            // Pulse: P cycles, then stay high while the button is still held.
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1 && !m_deb) m_hold <= 1'b1;
            end else if (m_hold) begin
                if (m_deb) m_hold <= 1'b0;
            end else if (m_trig) begin
                m_left <= P;
            end
            m_cause <= (CAUSE_CLR ? 4'h0 : m_cause) | m_set;
            if (WDT_KICK || !m_locked || (m_idle && m_trig)) m_wdt_age <= 0;
            else if (m_idle) m_wdt_age <= m_wdt_age + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: actual %0d, required %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge MAIN_CLK) begin
        check("cycle_ext_reset", int'(EXT_RESET), int'(m_ext));
        check("cycle_dcm_locked", int'(DCM_LOCKED), int'(m_locked));
        check("cycle_reset_cause", int'(RESET_CAUSE), int'(m_cause));
    end

    always @(negedge MAIN_CLK) begin
        if (EXT_RESET === 1'b1) ext_high_cnt <= ext_high_cnt + 1;
    end

    task automatic tick();
        @(posedge MAIN_CLK);
        #2;
    endtask

    task automatic wait_dcm_high(input int limit, output int n);
        n = 0;
        while (n <= limit) begin
            tick();
            n++;
            if (DCM_LOCKED === 1'b1) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running, required finished");
        $fatal(1);
    end

    initial begin
        int n;
        int e0;
        int first_low;

        MAIN_RESET_N   = 1'b0;
        RESET_BTN_N    = 1'b1;
        DCM_LOCKED_RAW = 1'b1;
        SOFT_RESET_REQ = 1'b0;
        CAUSE_CLR      = 1'b0;
        WDT_KICK       = 1'b1;
        repeat (3) tick();
        check("reset_ext_reset", int'(EXT_RESET), 0);
        check("reset_dcm_locked", int'(DCM_LOCKED), 0);
        check("reset_cause", int'(RESET_CAUSE), 0);

        // Power-on: lock qualified SYNC_STAGES + LOCK_STABLE_CNT cycles after release.
        MAIN_RESET_N = 1'b1;
        wait_dcm_high(40, n);
        check("poweron_lock_latency", n, 18);
        check("poweron_ext_reset", int'(EXT_RESET), 0);
        check("poweron_cause", int'(RESET_CAUSE), 0);

        // Short button glitch is discarded.
        e0 = ext_high_cnt;
        RESET_BTN_N = 1'b0;
        repeat (5) tick();
        RESET_BTN_N = 1'b1;
        repeat (30) tick();
        check("glitch_no_pulse", ext_high_cnt - e0, 0);
        check("glitch_cause", int'(RESET_CAUSE), 0);

        // Long press: pulse from deb edge+1 until debounced release (HOLD).
        e0 = ext_high_cnt;
        RESET_BTN_N = 1'b0;
        repeat (40) tick();
        RESET_BTN_N = 1'b1;
        repeat (40) tick();
        check("button_pulse_width", ext_high_cnt - e0, 40);
        check("button_cause", int'(RESET_CAUSE), 1);
        check("button_ext_low_after", int'(EXT_RESET), 0);

        // Two soft requests 10 cycles apart make one 32-cycle pulse.
        e0 = ext_high_cnt;
        SOFT_RESET_REQ = 1'b1;
        tick();
        SOFT_RESET_REQ = 1'b0;
        repeat (9) tick();
        SOFT_RESET_REQ = 1'b1;
        tick();
        SOFT_RESET_REQ = 1'b0;
        repeat (50) tick();
        check("soft_pulse_width", ext_high_cnt - e0, 32);
        check("soft_cause", int'(RESET_CAUSE), 3);

        CAUSE_CLR = 1'b1;
        tick();
        CAUSE_CLR = 1'b0;
        check("cause_clear", int'(RESET_CAUSE), 0);

        CAUSE_CLR      = 1'b1;
        SOFT_RESET_REQ = 1'b1;
        tick();
        CAUSE_CLR      = 1'b0;
        SOFT_RESET_REQ = 1'b0;
        check("clear_vs_set", int'(RESET_CAUSE), 2);
        repeat (40) tick();

        // Lock loss for 3 cycles.
        DCM_LOCKED_RAW = 1'b0;
        first_low = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (DCM_LOCKED === 1'b0 && first_low == 0) first_low = i;
        end
        DCM_LOCKED_RAW = 1'b1;
        check("lockloss_drop_latency", first_low, 3);
        check("lockloss_cause", int'(RESET_CAUSE), 6);
        wait_dcm_high(40, n);
        check("relock_latency", n, 18);

        // Main reset in the middle of a pulse.
        SOFT_RESET_REQ = 1'b1;
        tick();
        SOFT_RESET_REQ = 1'b0;
        repeat (9) tick();
        check("midpulse_ext_high", int'(EXT_RESET), 1);
        MAIN_RESET_N = 1'b0;
        #1;
        check("midpulse_ext_abort", int'(EXT_RESET), 0);
        check("midpulse_cause_abort", int'(RESET_CAUSE), 0);
        check("midpulse_dcm_abort", int'(DCM_LOCKED), 0);
        repeat (3) tick();
        MAIN_RESET_N = 1'b1;
        WDT_KICK     = 1'b0;
        e0 = ext_high_cnt;
        wait_dcm_high(40, n);
        check("postreset_lock_latency", n, 18);
        check("postreset_idle", ext_high_cnt - e0, 0);

`ifdef RESET_WDT_EN
        // No kicks: watchdog fires 100 cycles after lock qualification.
        n = 0;
        while (n <= 150) begin
            tick();
            n++;
            if (EXT_RESET === 1'b1) break;
        end
        check("wdt_timeout_latency", n, 100);
        repeat (40) tick();
        check("wdt_cause", int'(RESET_CAUSE), 8);
        e0 = ext_high_cnt;
        for (int i = 0; i < 1000; i++) begin
            WDT_KICK = (i % 50 == 0);
            tick();
        end
        WDT_KICK = 1'b0;
        check("wdt_kicked_no_pulse", ext_high_cnt - e0, 0);
`else
        // Without the watchdog, an unkicked idle period never produces a pulse.
        e0 = ext_high_cnt;
        repeat (200) tick();
        check("nowdt_no_pulse", ext_high_cnt - e0, 0);
        check("nowdt_cause", int'(RESET_CAUSE), 0);
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reset_src_filter.md
Name: reset_src_filter

Overview:
- Conditions the raw reset sources that feed the reset controller: the push-button reset, the software reset request, and the clock-manager lock.
- Synchronises and debounces these sources, qualifies lock stability, and generates a minimum-width EXT_RESET pulse.
- Outputs EXT_RESET and DCM_LOCKED connect directly to the same-named inputs of the reset controller.
- Keeps a sticky reset-cause register readable by the CPU.

Parameters:
SYNC_STAGES, 2, synchroniser depth for RESET_BTN_N and DCM_LOCKED_RAW (legal values ≥2).
BTN_DEB_CNT, 32'd100000, consecutive cycles a changed button level must hold before it is accepted.
LOCK_STABLE_CNT, 32'd1024, consecutive cycles raw lock must stay high before DCM_LOCKED rises.
EXT_PULSE_CNT, 32'd256, minimum EXT_RESET high width in cycles (legal values ≥1).
WDT_TIMEOUT, 32'h0100_0000, watchdog timeout in cycles (used only with RESET_WDT_EN).

Ports:
MAIN_CLK  in  1  single clock
MAIN_RESET_N  in  1  asynchronous active-low reset (power-on)
RESET_BTN_N  in  1  asynchronous push button, low = pressed
DCM_LOCKED_RAW  in  1  asynchronous clock-manager lock
SOFT_RESET_REQ  in  1  one-cycle software reset request, synchronous
CAUSE_CLR  in  1  one-cycle clear of RESET_CAUSE, synchronous
WDT_KICK  in  1  watchdog service pulse (ignored without RESET_WDT_EN)
EXT_RESET  out  1  conditioned reset request, active high
DCM_LOCKED  out  1  qualified lock
RESET_CAUSE  out  4  sticky causes: [0] button, [1] soft, [2] lock loss, [3] watchdog

Behaviour:
- Clocking and reset: one clock (MAIN_CLK). Reset is asynchronous, active-low (MAIN_RESET_N).
- Reset values:
  - EXT_RESET=0, DCM_LOCKED=0, RESET_CAUSE=4'h0.
  - Button synchroniser flops=1; debounced button state=1 (released).
  - Lock synchroniser flops=0; all counters=0; FSM=IDLE.
- Synchronisers: SYNC_STAGES flops each. Synchronised values are btn_s and lock_s.
- Debounce:
  - If btn_s != deb_btn, the counter increments; otherwise the counter clears.
  - When the counter reaches BTN_DEB_CNT-1 while btn_s still differs, deb_btn takes btn_s on the next edge and the counter clears.
  - Any glitch shorter than BTN_DEB_CNT cycles is discarded.
- Lock qualifier:
  - lock_s=0 clears the stable counter, and DCM_LOCKED drops on the next edge (no filtering on loss).
  - lock_s=1: the counter increments, saturating at LOCK_STABLE_CNT. DCM_LOCKED rises the cycle after the counter reaches LOCK_STABLE_CNT-1.
  - A falling edge of DCM_LOCKED (1 to 0) sets RESET_CAUSE[2].
- EXT_RESET FSM (states IDLE, ASSERT, HOLD):
  - IDLE: a trigger is a deb_btn falling edge, SOFT_RESET_REQ=1, or a watchdog expiry. On a trigger, go to ASSERT, set EXT_RESET=1 next edge, clear the pulse counter, and set the matching cause bit(s). Simultaneous triggers set all matching bits.
  - ASSERT: the pulse counter increments each cycle. Further triggers are ignored (no extension, no cause update). At count EXT_PULSE_CNT-1: go to IDLE if deb_btn=1, else go to HOLD.
  - HOLD: EXT_RESET stays 1 until deb_btn=1, then go to IDLE.
  - EXT_RESET=0 in IDLE.
- Pulse timing: EXT_RESET is high for exactly EXT_PULSE_CNT cycles if the button is already released. Trigger-to-EXT_RESET latency is 1 cycle from the registered trigger.
- RESET_CAUSE:
  - Bits are sticky and cleared only by CAUSE_CLR or MAIN_RESET_N.
  - A set and CAUSE_CLR in the same cycle leave the bit set.
  - EXT_RESET does not clear the register, so the cause survives the reset it causes.
- MAIN_RESET_N asserted mid-pulse aborts everything immediately to reset values.

Optional Feature:
- Macro: RESET_WDT_EN.
- With RESET_WDT_EN:
  - A 32-bit watchdog counter runs only while DCM_LOCKED=1 and FSM=IDLE.
  - The counter clears on WDT_KICK=1, on DCM_LOCKED=0, and when entering ASSERT.
  - When it reaches WDT_TIMEOUT-1, it generates a watchdog trigger (sets RESET_CAUSE[3]).
  - A kick in the same cycle as the timeout wins: no trigger.
- Without RESET_WDT_EN:
  - No watchdog logic is built.
  - WDT_KICK is ignored.
  - RESET_CAUSE[3] is tied to 0.

Test Plan (SYNC_STAGES=2, BTN_DEB_CNT=8, LOCK_STABLE_CNT=16, EXT_PULSE_CNT=32, WDT_TIMEOUT=100):
- Power-on: release MAIN_RESET_N with DCM_LOCKED_RAW=1 → DCM_LOCKED rises 2+16 cycles after release (±1); EXT_RESET=0; RESET_CAUSE=0.
- Button glitch: RESET_BTN_N low 5 cycles → no EXT_RESET, RESET_CAUSE unchanged. Then low 40 cycles → EXT_RESET high from deb edge+1 until the button is debounced released (HOLD exercised); RESET_CAUSE=4'h1.
- Soft request: SOFT_RESET_REQ pulse, then a second pulse 10 cycles later → single EXT_RESET of exactly 32 cycles; RESET_CAUSE[1]=1. CAUSE_CLR pulse → RESET_CAUSE=0. CAUSE_CLR coinciding with a new SOFT_RESET_REQ → bit[1] stays 1.
- Lock loss: DCM_LOCKED_RAW low 3 cycles → DCM_LOCKED=0 within 3 cycles; RESET_CAUSE[2]=1; DCM_LOCKED returns 16 cycles after lock_s is high again.
- Mid-pulse reset: assert MAIN_RESET_N at pulse cycle 10 → EXT_RESET=0 and RESET_CAUSE=0 immediately; FSM=IDLE after release.
- RESET_WDT_EN build: no kicks → EXT_RESET asserted 100 cycles after DCM_LOCKED rise; RESET_CAUSE[3]=1. Kicking every 50 cycles → no EXT_RESET for 1000 cycles.
